// File: rtl/beidou_pkg.sv
`default_nettype none
// ============================================================================
// Module   : beidou_pkg
// Brief    : Shared widths and saturating-arithmetic helpers for the BeiDou
//            integrate-and-dump datapath.
// Revision : 1.0  initial release
// ============================================================================
package beidou_pkg;

  localparam int IN_W_DEF  = 2;
  localparam int ACC_W_DEF = 25;
  localparam int CNT_W_DEF = 24;

  // Working width for the saturating helpers; accumulators up to 63 bits fit.
  localparam int SAT_W = 64;

  typedef logic signed [SAT_W-1:0] wide_t;

  // Signed add clamped to the symmetric range +/-(2^(w-1)-1).
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned w);
    wide_t s;
    wide_t lim;
    s   = a + b;
    lim = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    if (s > lim) return lim;
    if (s < -lim) return -lim;
    return s;
  endfunction

  // True when sat_add with the same operands had to clamp.
  function automatic logic sat_hit(input wide_t a, input wide_t b, input int unsigned w);
    wide_t s;
    wide_t lim;
    s   = a + b;
    lim = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    return (s > lim) || (s < -lim);
  endfunction

endpackage
`default_nettype wire

// File: rtl/iq_energy_pipe.sv
`default_nettype none
// ============================================================================
// Module   : iq_energy_pipe
// Brief    : Two-stage I^2 + Q^2 energy pipe. Stage 1 squares, stage 2 sums.
//            A flush drops in-flight valids while data registers hold.
// Revision : 1.0  initial release
// ============================================================================
module iq_energy_pipe
  import beidou_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [ACC_W-1:0]   i_dump_i,
  input  logic [ACC_W-1:0]   i_dump_q,
  output logic [2*ACC_W-1:0] o_energy,
  output logic               o_valid
);

  logic [2*ACC_W-1:0]        sq_i_q, sq_i_d;
  logic [2*ACC_W-1:0]        sq_q_q, sq_q_d;
  logic [2*ACC_W-1:0]        energy_q, energy_d;
  logic                      v1_q, v1_d;
  logic                      v2_q, v2_d;
  logic signed [2*ACC_W-1:0] ext_i, ext_q;

  // Square on stage 1, sum on stage 2; data only moves with a surviving valid.
  always_comb begin
    ext_i    = {{ACC_W{i_dump_i[ACC_W-1]}}, i_dump_i};
    ext_q    = {{ACC_W{i_dump_q[ACC_W-1]}}, i_dump_q};
    sq_i_d   = sq_i_q;
    sq_q_d   = sq_q_q;
    energy_d = energy_q;
    v1_d     = i_valid & ~i_flush;
    v2_d     = v1_q & ~i_flush;
    if (v1_d) begin
      sq_i_d = ext_i * ext_i;
      sq_q_d = ext_q * ext_q;
    end
    if (v2_d) begin
      energy_d = sq_i_q + sq_q_q;
    end
  end

  // Pipe registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sq_i_q   <= '0;
      sq_q_q   <= '0;
      energy_q <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
    end else begin
      sq_i_q   <= sq_i_d;
      sq_q_q   <= sq_q_d;
      energy_q <= energy_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
    end
  end

  assign o_energy = energy_q;
  assign o_valid  = v2_q;

endmodule
`default_nettype wire

// File: rtl/integrate_dump_nc_beidou.sv
`default_nettype none
// ============================================================================
// Module   : integrate_dump_nc_beidou
// Brief    : Coherent integrate-and-dump with saturating I/Q accumulators,
//            pipelined energy and non-coherent accumulation over NC_N dumps.
// Revision : 1.0  initial release
// ============================================================================
module integrate_dump_nc_beidou
  import beidou_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int NC_N  = 4,
  parameter int NC_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    shift_parse,
  input  logic                    in_en,
  input  logic [IN_W-1:0]         I_in,
  input  logic [IN_W-1:0]         Q_in,
  input  logic [CNT_W-1:0]        dump_len,
  output logic [ACC_W-1:0]        I_dump,
  output logic [ACC_W-1:0]        Q_dump,
  output logic                    coh_valid,
  output logic [2*ACC_W-1:0]      energy,
  output logic                    energy_valid,
  output logic [2*ACC_W+NC_W-1:0] nc_sum,
  output logic                    nc_valid,
  output logic                    ovf
);

  localparam int NC_CW = (NC_N > 1) ? $clog2(NC_N) : 1;
  localparam int SUM_W = 2*ACC_W + NC_W;

  // len_q == 0 marks "period start pending": a latched length is never 0.
  logic [CNT_W-1:0]        len_q, len_d, eff_len;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [ACC_W-1:0] dump_i_q, dump_i_d, dump_q_q, dump_q_d;
  logic                    coh_valid_q, coh_valid_d;
  logic                    ovf_q, ovf_d;
  logic [SUM_W-1:0]        nc_acc_q, nc_acc_d, nc_sum_q, nc_sum_d;
  logic [NC_CW-1:0]        nc_cnt_q, nc_cnt_d;
  logic                    nc_valid_q, nc_valid_d;
  logic                    accept, last;
  logic [2*ACC_W-1:0]      energy_w;
  logic                    energy_valid_w;

  // Period control, saturating accumulation, dump and non-coherent sum.
  always_comb begin
    len_d       = len_q;
    cnt_d       = cnt_q;
    acc_i_d     = acc_i_q;
    acc_q_d     = acc_q_q;
    dump_i_d    = dump_i_q;
    dump_q_d    = dump_q_q;
    coh_valid_d = 1'b0;
    ovf_d       = ovf_q;
    nc_acc_d    = nc_acc_q;
    nc_cnt_d    = nc_cnt_q;
    nc_sum_d    = nc_sum_q;
    nc_valid_d  = 1'b0;

    eff_len = len_q;
    if (len_q == '0) begin
      eff_len = (dump_len == '0) ? CNT_W'(1) : dump_len;
    end
    accept = in_en & ~shift_parse;
    last   = accept & (cnt_q == eff_len - CNT_W'(1));

    if (shift_parse) begin
      // Abort: the sample in this cycle is discarded and nothing dumps.
      len_d    = '0;
      cnt_d    = '0;
      acc_i_d  = '0;
      acc_q_d  = '0;
      ovf_d    = 1'b0;
      nc_acc_d = '0;
      nc_cnt_d = '0;
    end else begin
      len_d = eff_len;
      if (accept) begin
        ovf_d = ovf_q
              | sat_hit(SAT_W'(acc_i_q), SAT_W'($signed(I_in)), ACC_W)
              | sat_hit(SAT_W'(acc_q_q), SAT_W'($signed(Q_in)), ACC_W);
        acc_i_d = ACC_W'(sat_add(SAT_W'(acc_i_q), SAT_W'($signed(I_in)), ACC_W));
        acc_q_d = ACC_W'(sat_add(SAT_W'(acc_q_q), SAT_W'($signed(Q_in)), ACC_W));
        cnt_d   = cnt_q + CNT_W'(1);
        if (last) begin
          dump_i_d    = acc_i_d;
          dump_q_d    = acc_q_d;
          coh_valid_d = 1'b1;
          acc_i_d     = '0;
          acc_q_d     = '0;
          cnt_d       = '0;
          len_d       = '0;
        end
      end
      if (energy_valid_w) begin
        if (nc_cnt_q == NC_CW'(NC_N - 1)) begin
          nc_sum_d   = nc_acc_q + SUM_W'(energy_w);
          nc_valid_d = 1'b1;
          nc_acc_d   = '0;
          nc_cnt_d   = '0;
        end else begin
          nc_acc_d = nc_acc_q + SUM_W'(energy_w);
          nc_cnt_d = nc_cnt_q + NC_CW'(1);
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q       <= '0;
      cnt_q       <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      dump_i_q    <= '0;
      dump_q_q    <= '0;
      coh_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      nc_acc_q    <= '0;
      nc_cnt_q    <= '0;
      nc_sum_q    <= '0;
      nc_valid_q  <= 1'b0;
    end else begin
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      dump_i_q    <= dump_i_d;
      dump_q_q    <= dump_q_d;
      coh_valid_q <= coh_valid_d;
      ovf_q       <= ovf_d;
      nc_acc_q    <= nc_acc_d;
      nc_cnt_q    <= nc_cnt_d;
      nc_sum_q    <= nc_sum_d;
      nc_valid_q  <= nc_valid_d;
    end
  end

  iq_energy_pipe #(
    .ACC_W (ACC_W)
  ) u_energy (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_flush  (shift_parse),
    .i_valid  (coh_valid_q),
    .i_dump_i (dump_i_q),
    .i_dump_q (dump_q_q),
    .o_energy (energy_w),
    .o_valid  (energy_valid_w)
  );

  assign I_dump       = dump_i_q;
  assign Q_dump       = dump_q_q;
  assign coh_valid    = coh_valid_q;
  assign energy       = energy_w;
  assign energy_valid = energy_valid_w;
  assign nc_sum       = nc_sum_q;
  assign nc_valid     = nc_valid_q;
  assign ovf          = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_integrate_dump_nc_beidou.sv
`default_nettype none
// ============================================================================
// Module   : tb_integrate_dump_nc_beidou
// Brief    : Scoreboard bench for integrate_dump_nc_beidou (ACC_W=4 build so
//            saturation is reachable with short periods).
// Revision : 1.0  initial release
// ============================================================================
module tb_integrate_dump_nc_beidou;

  localparam int IN_W  = 2;
  localparam int ACC_W = 4;
  localparam int CNT_W = 8;
  localparam int NC_N  = 4;
  localparam int NC_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    shift_parse = 1'b0;
  logic                    in_en = 1'b0;
  logic [IN_W-1:0]         I_in = '0;
  logic [IN_W-1:0]         Q_in = '0;
  logic [CNT_W-1:0]        dump_len = 8'd4;
  logic [ACC_W-1:0]        I_dump, Q_dump;
  logic                    coh_valid, energy_valid, nc_valid, ovf;
  logic [2*ACC_W-1:0]      energy;
  logic [2*ACC_W+NC_W-1:0] nc_sum;

  always #5 clk = ~clk;

  integrate_dump_nc_beidou #(
    .IN_W (IN_W), .ACC_W (ACC_W), .CNT_W (CNT_W), .NC_N (NC_N), .NC_W (NC_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .shift_parse  (shift_parse),
    .in_en        (in_en),
    .I_in         (I_in),
    .Q_in         (Q_in),
    .dump_len     (dump_len),
    .I_dump       (I_dump),
    .Q_dump       (Q_dump),
    .coh_valid    (coh_valid),
    .energy       (energy),
    .energy_valid (energy_valid),
    .nc_sum       (nc_sum),
    .nc_valid     (nc_valid),
    .ovf          (ovf)
  );

  typedef struct { int due; logic [ACC_W-1:0] i; logic [ACC_W-1:0] q; } coh_t;
  typedef struct { int due; logic [2*ACC_W-1:0] v; } en_t;
  typedef struct { int due; logic [2*ACC_W+NC_W-1:0] v; } nc_t;

  coh_t coh_q[$];
  en_t  en_q[$];
  nc_t  nc_q[$];
  coh_t ce;
  en_t  ee;
  nc_t  ne;

  int edge_n = 0;
  int vectors = 0;
  int miscompares = 0;

  // Edge index: after a step returns, edge_n names the edge just taken.
  initial forever begin
    @(posedge clk);
    edge_n++;
  end

  // Scoreboard monitor: every strobe must match the head entry in value and edge.
  initial forever begin
    @(negedge clk);
    if (coh_valid === 1'b1) begin
      vectors++;
      if (coh_q.size() == 0) begin
        miscompares++;
        $display("FAIL coh_unexpected edge=%0d I=%0d Q=%0d", edge_n, $signed(I_dump), $signed(Q_dump));
      end else begin
        ce = coh_q.pop_front();
        if (I_dump !== ce.i || Q_dump !== ce.q || edge_n !== ce.due) begin
          miscompares++;
          $display("FAIL coh_dump got I=%0d Q=%0d edge=%0d want I=%0d Q=%0d edge=%0d",
                   $signed(I_dump), $signed(Q_dump), edge_n, $signed(ce.i), $signed(ce.q), ce.due);
        end
      end
    end
    if (coh_q.size() > 0 && coh_q[0].due < edge_n) begin
      vectors++; miscompares++;
      $display("FAIL coh_missing want edge=%0d now=%0d", coh_q[0].due, edge_n);
      void'(coh_q.pop_front());
    end
    if (energy_valid === 1'b1) begin
      vectors++;
      if (en_q.size() == 0) begin
        miscompares++;
        $display("FAIL energy_unexpected edge=%0d energy=%0d", edge_n, energy);
      end else begin
        ee = en_q.pop_front();
        if (energy !== ee.v || edge_n !== ee.due) begin
          miscompares++;
          $display("FAIL energy got %0d edge=%0d want %0d edge=%0d", energy, edge_n, ee.v, ee.due);
        end
      end
    end
    if (en_q.size() > 0 && en_q[0].due < edge_n) begin
      vectors++; miscompares++;
      $display("FAIL energy_missing want edge=%0d now=%0d", en_q[0].due, edge_n);
      void'(en_q.pop_front());
    end
    if (nc_valid === 1'b1) begin
      vectors++;
      if (nc_q.size() == 0) begin
        miscompares++;
        $display("FAIL nc_unexpected edge=%0d nc_sum=%0d", edge_n, nc_sum);
      end else begin
        ne = nc_q.pop_front();
        if (nc_sum !== ne.v || edge_n !== ne.due) begin
          miscompares++;
          $display("FAIL nc_sum got %0d edge=%0d want %0d edge=%0d", nc_sum, edge_n, ne.v, ne.due);
        end
      end
    end
    if (nc_q.size() > 0 && nc_q[0].due < edge_n) begin
      vectors++; miscompares++;
      $display("FAIL nc_missing want edge=%0d now=%0d", nc_q[0].due, edge_n);
      void'(nc_q.pop_front());
    end
  end

  // One clock of stimulus; inputs change 1 time unit after the edge.
  task automatic step(input logic en, input logic [1:0] i, input logic [1:0] q, input logic sp);
    in_en = en; I_in = i; Q_in = q; shift_parse = sp;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(1'b1, 2'b01, 2'b01, 1'b0);
    step(1'b1, 2'b01, 2'b01, 1'b0);
    vectors++;
    if ({I_dump, Q_dump, energy, nc_sum} !== '0) begin
      miscompares++;
      $display("FAIL reset_data got I=%0d Q=%0d e=%0d nc=%0d want all 0", I_dump, Q_dump, energy, nc_sum);
    end
    vectors++;
    if ({coh_valid, energy_valid, nc_valid, ovf} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 0000", {coh_valid, energy_valid, nc_valid, ovf});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    dump_len = 8'd4;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 2'b01, 2'b11, 1'b0);
      if (k % 4 == 3) begin
        coh_q.push_back('{edge_n, 4'd4, 4'(-4)});
        en_q.push_back('{edge_n + 2, 8'd32});
      end
      if (k == 15) nc_q.push_back('{edge_n + 3, 10'd128});
    end
    idle(6);
    vectors++;
    if (coh_q.size() + en_q.size() + nc_q.size() != 0) begin
      miscompares++;
      $display("FAIL basic_drain got %0d pending want 0", coh_q.size() + en_q.size() + nc_q.size());
    end
    vectors++;
    if (I_dump !== 4'd4 || energy !== 8'd32 || nc_sum !== 10'd128) begin
      miscompares++;
      $display("FAIL basic_hold got I=%0d e=%0d nc=%0d want 4 32 128", I_dump, energy, nc_sum);
    end
  endtask

  task automatic test_in_en_toggle;
    step(1'b0, 2'b00, 2'b00, 1'b1);
    dump_len = 8'd3;
    for (int k = 0; k < 6; k++) begin
      step((k % 2) == 0, 2'b01, 2'b00, 1'b0);
      if (k == 4) begin
        coh_q.push_back('{edge_n, 4'd3, 4'd0});
        en_q.push_back('{edge_n + 2, 8'd9});
      end
    end
    idle(5);
  endtask

  task automatic test_saturation;
    step(1'b0, 2'b00, 2'b00, 1'b1);
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_pre got %b want 0", ovf);
    end
    dump_len = 8'd10;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 2'b01, 2'b11, 1'b0);
      if (k == 9) begin
        coh_q.push_back('{edge_n, 4'd7, 4'(-7)});
        en_q.push_back('{edge_n + 2, 8'd98});
      end
    end
    idle(8);
    vectors++;
    if (ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_sticky got %b want 1", ovf);
    end
    step(1'b0, 2'b00, 2'b00, 1'b1);
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear got %b want 0", ovf);
    end
  endtask

  task automatic test_shift_mid;
    dump_len = 8'd4;
    // A dump whose energy is still in flight when shift_parse arrives.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 2'b01, 2'b11, 1'b0);
      if (k == 3) coh_q.push_back('{edge_n, 4'd4, 4'(-4)});
    end
    step(1'b0, 2'b00, 2'b00, 1'b1);
    // shift_parse on the 4th sample: no dump, accumulator cleared.
    for (int k = 0; k < 4; k++) step(1'b1, 2'b01, 2'b11, k == 3);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 2'b01, 2'b11, 1'b0);
      if (k == 3) begin
        coh_q.push_back('{edge_n, 4'd4, 4'(-4)});
        en_q.push_back('{edge_n + 2, 8'd32});
      end
    end
    idle(6);
    vectors++;
    if (coh_q.size() + en_q.size() + nc_q.size() != 0) begin
      miscompares++;
      $display("FAIL shift_drain got %0d pending want 0", coh_q.size() + en_q.size() + nc_q.size());
    end
  endtask

  task automatic test_back_to_back;
    step(1'b0, 2'b00, 2'b00, 1'b1);
    dump_len = 8'd0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 2'b01, 2'b01, 1'b0);
      coh_q.push_back('{edge_n, 4'd1, 4'd1});
      en_q.push_back('{edge_n + 2, 8'd2});
      if (k == 3) nc_q.push_back('{edge_n + 3, 10'd8});
    end
    idle(6);
  endtask

  task automatic test_reset_mid;
    dump_len = 8'd4;
    step(1'b0, 2'b00, 2'b00, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 2'b01, 2'b11, 1'b0);
      if (k == 3) coh_q.push_back('{edge_n, 4'd4, 4'(-4)});
    end
    step(1'b1, 2'b01, 2'b11, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 2'b01, 2'b11, 1'b0);
    vectors++;
    if ({I_dump, Q_dump, energy, nc_sum} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_data got I=%0d Q=%0d e=%0d nc=%0d want all 0", I_dump, Q_dump, energy, nc_sum);
    end
    vectors++;
    if ({coh_valid, energy_valid, nc_valid, ovf} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_mid_flags got %b want 0000", {coh_valid, energy_valid, nc_valid, ovf});
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 2'b01, 2'b11, 1'b0);
      if (k == 3) begin
        coh_q.push_back('{edge_n, 4'd4, 4'(-4)});
        en_q.push_back('{edge_n + 2, 8'd32});
      end
    end
    idle(6);
    vectors++;
    if (coh_q.size() + en_q.size() + nc_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_mid_drain got %0d pending want 0", coh_q.size() + en_q.size() + nc_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_in_en_toggle;
    test_saturation;
    test_shift_mid;
    test_back_to_back;
    test_reset_mid;
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
